tx_crc_framer: RTL and testbench

TX_CRC_FRAMER -- requirements
Module: tx_crc_framer

---
 rtl/tx_crc_framer.sv | 140 ++++++++++++++
 tb/tb_tx_crc_framer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/tx_crc_framer.sv
// -----------------------------------------------------------------------------
// tx_crc_framer
//
// Transmit-side framer that tracks frame boundaries from K-character flags and
// optionally replaces each frame's trailer word with a CRC-32 computed over
// the frame's data words.
//
// Word classes (padding words, k all ones, are transparent to the history):
//   SOF     : k == 1 and the previous two non-padding words had k[0] = 1
//   TRAILER : k == 0, previous non-padding k[0] = 1, the one before it = 0
//   DATA    : k == 0 and not a TRAILER
//   other   : comma / control words, passed through untouched
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   d            input data word (DW bits)
//   k            per-byte K flags (BYTES bits)
//   crc_ins_en   1 = replace trailer with CRC, 0 = pass trailer through
//   dout         registered output data
//   kout         registered output K flags
//   tx_crc_r     high on the cycle dout carries an inserted CRC
//   frame_words  data words counted in the current frame (saturating)
//   frame_ovf    sticky: frame grew beyond MAX_FRAME words
//   err_no_sof   one-cycle pulse: trailer seen with no open frame
// -----------------------------------------------------------------------------
module tx_crc_framer #(
  parameter int          BYTES     = 4,            // legal range 4..8
  parameter logic [31:0] CRC_POLY  = 32'h04C11DB7,
  parameter logic [31:0] CRC_INIT  = 32'hFFFFFFFF,
  parameter int          MAX_FRAME = 1024,
  localparam int         DW        = 8 * BYTES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    d,
  input  logic [BYTES-1:0] k,
  input  logic             crc_ins_en,
  output logic [DW-1:0]    dout,
  output logic [BYTES-1:0] kout,
  output logic             tx_crc_r,
  output logic [15:0]      frame_words,
  output logic             frame_ovf,
  output logic             err_no_sof
);

  typedef enum logic {S_IDLE, S_OPEN} state_t;

  localparam logic [BYTES-1:0] K_SOF   = BYTES'(1);
  localparam logic [15:0]      MAX_CNT = 16'(MAX_FRAME);

  // MSB-first, non-reflected CRC over a whole word in one step.
  function automatic logic [31:0] crc_step(input logic [31:0] c,
                                           input logic [DW-1:0] data);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = r[31] ^ data[i];
      r  = {r[30:0], 1'b0};
      if (fb) r = r ^ CRC_POLY;
    end
    return r;
  endfunction

  state_t             state_q;
  logic               kr_q, krr_q;
  logic [31:0]        crc_q, crc_d;
  logic [15:0]        fw_q, fw_d;
  logic               ovf_q;
  logic [DW-1:0]      dout_q;
  logic [BYTES-1:0]   kout_q;
  logic               tx_q;
  logic               err_q;

  logic is_pad, is_sof, is_trl, is_data;

  always_comb begin
    is_pad  = (k == '1);
    // k == 1 and k == 0 can never be all ones, so these already exclude padding.
    is_sof  = (k == K_SOF) && kr_q && krr_q;
    is_trl  = (k == '0) && kr_q && !krr_q;
    is_data = (k == '0) && !is_trl;
    crc_d   = crc_step(crc_q, d);
    fw_d    = (fw_q == 16'hFFFF) ? fw_q : fw_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      kr_q    <= 1'b0;
      krr_q   <= 1'b0;
      crc_q   <= CRC_INIT;
      fw_q    <= 16'd0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
      kout_q  <= '0;
      tx_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dout_q <= d;
      kout_q <= k;
      tx_q   <= 1'b0;
      err_q  <= 1'b0;

      if (!is_pad) begin
        krr_q <= kr_q;
        kr_q  <= k[0];
      end

      // SOF takes priority; the classes are otherwise disjoint by k value.
      if (is_sof) begin
        state_q <= S_OPEN;
        crc_q   <= CRC_INIT;
        fw_q    <= 16'd0;
        ovf_q   <= 1'b0;
      end else if (is_trl) begin
        state_q <= S_IDLE;
        if (state_q == S_IDLE) err_q <= 1'b1;
        if (crc_ins_en) begin
          dout_q <= DW'(crc_q);
          tx_q   <= 1'b1;
        end
      end else if (is_data) begin
        // Words outside a frame still feed the CRC and the counter.
        crc_q <= crc_d;
        fw_q  <= fw_d;
        if (fw_q == MAX_CNT) ovf_q <= 1'b1;
      end
    end
  end

  assign dout        = dout_q;
  assign kout        = kout_q;
  assign tx_crc_r    = tx_q;
  assign frame_words = fw_q;
  assign frame_ovf   = ovf_q;
  assign err_no_sof  = err_q;

endmodule

// File: tb/tb_tx_crc_framer.sv
// -----------------------------------------------------------------------------
// tb_tx_crc_framer
//
// Drives a 4-byte and an 8-byte framer (both with MAX_FRAME = 4) from the same
// stimulus stream. A behavioural model keeps the frame bytes in queues and
// computes the CRC over the byte stream when a trailer appears; expected
// outputs are queued on the driving edge and checked by an independent monitor.
// -----------------------------------------------------------------------------
module tb_tx_crc_framer;

  localparam logic [31:0] POLY  = 32'h04C11DB7;
  localparam logic [31:0] INIT  = 32'hFFFFFFFF;
  localparam int          MAXF  = 4;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [31:0] da;
    logic [3:0]  ka;
    logic [63:0] db;
    logic [7:0]  kb;
    logic        tx;
    logic [15:0] fw;
    logic        ovf;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] d_a = '0;
  logic [3:0]  k_a = '0;
  logic [63:0] d_b = '0;
  logic [7:0]  k_b = '0;
  logic        ins_en = 1'b1;

  logic [31:0] dout_a;
  logic [3:0]  kout_a;
  logic        tx_a, ovf_a, err_a;
  logic [15:0] fw_a;
  logic [63:0] dout_b;
  logic [7:0]  kout_b;
  logic        tx_b, ovf_b, err_b;
  logic [15:0] fw_b;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t sb[$];

  // Model state
  bit          m_kr = 0, m_krr = 0, m_open = 0, m_ovf = 0;
  logic [15:0] m_fw = '0;
  bq_t         qa, qb;

  always #5 clk = ~clk;

  tx_crc_framer #(.BYTES(4), .MAX_FRAME(MAXF)) dut_a (
    .clk(clk), .rst_n(rst_n), .d(d_a), .k(k_a), .crc_ins_en(ins_en),
    .dout(dout_a), .kout(kout_a), .tx_crc_r(tx_a), .frame_words(fw_a),
    .frame_ovf(ovf_a), .err_no_sof(err_a));

  tx_crc_framer #(.BYTES(8), .MAX_FRAME(MAXF)) dut_b (
    .clk(clk), .rst_n(rst_n), .d(d_b), .k(k_b), .crc_ins_en(ins_en),
    .dout(dout_b), .kout(kout_b), .tx_crc_r(tx_b), .frame_words(fw_b),
    .frame_ovf(ovf_b), .err_no_sof(err_b));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // CRC of a byte stream, first byte first, each byte MSB first.
  function automatic logic [31:0] crc_of(input bq_t q);
    logic [31:0] c;
    c = INIT;
    foreach (q[i]) begin
      c = c ^ {q[i], 24'h0};
      repeat (8) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  task automatic send(input logic [3:0] ka, input logic [31:0] da,
                      input logic [63:0] db, input logic ins);
    logic [7:0] kb;
    exp_t       e;
    bit         sof, trl, dat;
    if (ka == 4'hF)                    kb = 8'hFF;
    else if (ka == 4'h0 || ka == 4'h1) kb = {4'h0, ka};
    else                               kb = {4'($urandom), ka};
    @(negedge clk);
    rst_n = 1'b1; d_a = da; k_a = ka; d_b = db; k_b = kb; ins_en = ins;
    e = '0;
    e.da = da; e.ka = ka; e.db = db; e.kb = kb;
    if (ka != 4'hF) begin
      sof = (ka == 4'h1) && m_kr && m_krr;
      trl = (ka == 4'h0) && m_kr && !m_krr;
      dat = (ka == 4'h0) && !trl;
      if (sof) begin
        qa.delete(); qb.delete();
        m_fw = '0; m_ovf = 0; m_open = 1;
      end else if (trl) begin
        e.err = !m_open;
        if (ins) begin
          e.da = crc_of(qa);
          e.db = {32'h0, crc_of(qb)};
          e.tx = 1'b1;
        end
        m_open = 0;
      end else if (dat) begin
        for (int i = 3; i >= 0; i--) qa.push_back(da[8*i +: 8]);
        for (int i = 7; i >= 0; i--) qb.push_back(db[8*i +: 8]);
        if (m_fw == 16'(MAXF)) m_ovf = 1;
        if (m_fw != 16'hFFFF) m_fw = m_fw + 16'd1;
      end
      m_krr = m_kr;
      m_kr  = ka[0];
    end
    e.fw  = m_fw;
    e.ovf = m_ovf;
    sb.push_back(e);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0; d_a = $urandom; k_a = '0; d_b = {$urandom, $urandom}; k_b = '0; ins_en = 1'b1;
      m_kr = 0; m_krr = 0; m_open = 0; m_fw = '0; m_ovf = 0;
      qa.delete(); qb.delete();
      sb.push_back('0);
      #1;
      chk("async_rst_dout", dout_a, 64'd0);
      chk("async_rst_fw", fw_b, 64'd0);
    end
  endtask

  task automatic padw(input bit p);
    if (p) send(4'hF, $urandom, {$urandom, $urandom}, 1'($urandom));
  endtask

  task automatic frame(input logic ins, input int n, input bit pad, input bit basic);
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      padw(pad); send(4'h1, $urandom, {$urandom, $urandom}, ins);
    end
    for (int i = 0; i < n; i++) begin
      padw(pad);
      w = basic ? 32'(32'h11111111 * (i + 1)) : $urandom;
      send(4'h0, w, {$urandom, w}, ins);
    end
    padw(pad); send(4'h1, 32'h000000BC, {$urandom, $urandom}, ins);
    padw(pad); send(4'h0, $urandom, {$urandom, $urandom}, ins);
    padw(pad);
  endtask

  // Monitor: one expected record per clock edge after it was driven.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("dout_a", dout_a, e.da);
        chk("kout_a", kout_a, e.ka);
        chk("dout_b", dout_b, e.db);
        chk("kout_b", kout_b, e.kb);
        chk("tx_a", tx_a, e.tx);
        chk("tx_b", tx_b, e.tx);
        chk("fw_a", fw_a, e.fw);
        chk("fw_b", fw_b, e.fw);
        chk("ovf_a", ovf_a, e.ovf);
        chk("ovf_b", ovf_b, e.ovf);
        chk("err_a", err_a, e.err);
        chk("err_b", err_b, e.err);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    do_reset(3);
    frame(1'b1, 3, 1'b0, 1'b1);   // basic frame
    frame(1'b1, 3, 1'b1, 1'b1);   // padding everywhere
    frame(1'b0, 3, 1'b0, 1'b1);   // insertion disabled
    frame(1'b1, 5, 1'b0, 1'b0);   // overflow
    frame(1'b1, 2, 1'b0, 1'b0);   // SOF clears overflow
    // Reset mid-frame, then a trailer with no SOF
    for (int i = 0; i < 3; i++) send(4'h1, $urandom, {$urandom, $urandom}, 1'b1);
    send(4'h0, 32'hDEADBEEF, {$urandom, $urandom}, 1'b1);
    send(4'h0, 32'hCAFEF00D, {$urandom, $urandom}, 1'b1);
    do_reset(1);
    send(4'h1, 32'h000000BC, {$urandom, $urandom}, 1'b1);
    send(4'h0, $urandom, {$urandom, $urandom}, 1'b1);
    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        frame(1'($urandom), $urandom_range(0, 7), 1'($urandom), 1'b0);
      end else if (r <= 8) begin
        case ($urandom_range(0, 3))
          0:       send(4'h0, $urandom, {$urandom, $urandom}, 1'($urandom));
          1:       send(4'h1, $urandom, {$urandom, $urandom}, 1'($urandom));
          2:       send(4'hF, $urandom, {$urandom, $urandom}, 1'($urandom));
          default: send(4'($urandom), $urandom, {$urandom, $urandom}, 1'($urandom));
        endcase
      end else begin
        do_reset($urandom_range(1, 2));
      end
    end
    send(4'hF, $urandom, {$urandom, $urandom}, 1'b1);
    send(4'hF, $urandom, {$urandom, $urandom}, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
